// File: rtl/cedge_pkg.sv
// ---------------------------------------------------------------------------
// cedge_pkg
// Types and defaults shared by the Canny edge pipeline stages.
//   dir_t        : quantised gradient direction range carried alongside each
//                  magnitude (00 horizontal, 01 45deg, 10 vertical, 11 135deg)
//   nms_state_t  : frame-tracking state of the non-maximum suppression stage
//   NBIT_MAG_DEF : default gradient magnitude width
// ---------------------------------------------------------------------------
package cedge_pkg;

  typedef enum logic [1:0] {
    DIR_H   = 2'b00,
    DIR_45  = 2'b01,
    DIR_V   = 2'b10,
    DIR_135 = 2'b11
  } dir_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } nms_state_t;

  localparam int NBIT_MAG_DEF = 12;

endpackage

// File: rtl/nms_line_buffer.sv
// ---------------------------------------------------------------------------
// nms_line_buffer
// Single-port circular line delay. The word stored at a column address is
// returned (read-before-write) in the same cycle that the new word for that
// column is written, so the output is exactly one line older than the input.
// The read is asynchronous so that a full 3x3 window is available in the
// cycle of the completing input beat.
// Ports:
//   clk     : write clock, rising edge
//   we      : write enable (one accepted pixel)
//   addr    : column address, 0..DEPTH-1
//   wr_data : word for the current line at addr
//   rd_data : word written at addr one line earlier
// ---------------------------------------------------------------------------
module nms_line_buffer #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 640,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are never reset: every location is rewritten before it is used
  // to build an output window.
  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_nms.sv
// ---------------------------------------------------------------------------
// sobel_nms
// Non-maximum suppression for the Canny pipeline. Consumes a raster stream of
// gradient magnitude plus 2-bit direction range, forms a 3x3 magnitude window
// from two line buffers, and zeroes every interior centre pixel that is not a
// local maximum along its gradient direction (ties are kept).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset
//   i_sof   : start of frame, qualified by i_valid, marks pixel (0,0)
//   i_valid : input beat valid (no backpressure, gaps allowed)
//   i_mag   : gradient magnitude of current pixel
//   i_dir   : direction range of current pixel
//   o_valid : one-cycle pulse per interior output pixel
//   o_mag   : centre magnitude or 0 (holds while o_valid=0)
//   o_eof   : set with the last output of a complete frame (holds while
//             o_valid=0)
// An input beat at (r,c), r>=2 and c>=2, completes the window centred at
// (r-1,c-1); its output appears one cycle later.
// ---------------------------------------------------------------------------
module sobel_nms
  import cedge_pkg::*;
#(
  parameter int NBIT_MAG = NBIT_MAG_DEF,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sof,
  input  logic                i_valid,
  input  logic [NBIT_MAG-1:0] i_mag,
  input  logic [1:0]          i_dir,
  output logic                o_valid,
  output logic [NBIT_MAG-1:0] o_mag,
  output logic                o_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = NBIT_MAG + 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // -------------------------------------------------------------------------
  // Frame tracking
  // -------------------------------------------------------------------------
  nms_state_t    state, state_next;
  logic [CW-1:0] col, col_next;
  logic [RW-1:0] row, row_next;

  logic          accept;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          last_col;
  logic          last_pix;

  // A sof beat is always pixel (0,0): it starts a frame from IDLE and aborts
  // a frame in progress. Non-sof beats only count while a frame is running.
  assign accept   = i_valid && (i_sof || (state == ST_RUN));
  assign cur_col  = i_sof ? '0 : col;
  assign cur_row  = i_sof ? '0 : row;
  assign last_col = (cur_col == COL_LAST);
  assign last_pix = last_col && (cur_row == ROW_LAST);

  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    if (accept) begin
      if (last_col) begin
        col_next = '0;
        if (cur_row == ROW_LAST) begin
          row_next   = '0;
          state_next = ST_IDLE;
        end else begin
          row_next   = cur_row + 1'b1;
          state_next = ST_RUN;
        end
      end else begin
        col_next   = cur_col + 1'b1;
        row_next   = cur_row;
        state_next = ST_RUN;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      row   <= row_next;
    end
  end

  // -------------------------------------------------------------------------
  // Line buffers
  // mid holds row r-1 as {dir,mag} so the centre direction travels with the
  // centre magnitude; top holds row r-2 (magnitude only) and is fed from the
  // word mid is about to overwrite.
  // -------------------------------------------------------------------------
  logic [PW-1:0]       mid_rd;
  logic [NBIT_MAG-1:0] top_rd;

  nms_line_buffer #(
    .WIDTH (PW),
    .DEPTH (IMG_W)
  ) u_lb_mid (
    .clk     (i_clk),
    .we      (accept),
    .addr    (cur_col),
    .wr_data ({i_dir, i_mag}),
    .rd_data (mid_rd)
  );

  nms_line_buffer #(
    .WIDTH (NBIT_MAG),
    .DEPTH (IMG_W)
  ) u_lb_top (
    .clk     (i_clk),
    .we      (accept),
    .addr    (cur_col),
    .wr_data (mid_rd[NBIT_MAG-1:0]),
    .rd_data (top_rd)
  );

  // -------------------------------------------------------------------------
  // 3x3 window: index 0 = row r-2, 1 = row r-1, 2 = row r.
  // Tap 0 (column c) is the live column; taps 1 and 2 (columns c-1, c-2) are
  // shifted in on every accepted beat.
  // -------------------------------------------------------------------------
  logic [NBIT_MAG-1:0] live_mag [3];
  logic [NBIT_MAG-1:0] tap1_mag [3];
  logic [NBIT_MAG-1:0] tap2_mag [3];
  dir_t                ctr_dir;

  assign live_mag[0] = top_rd;
  assign live_mag[1] = mid_rd[NBIT_MAG-1:0];
  assign live_mag[2] = i_mag;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 3; i++) begin
        tap1_mag[i] <= '0;
        tap2_mag[i] <= '0;
      end
      ctr_dir <= DIR_H;
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        tap1_mag[i] <= live_mag[i];
        tap2_mag[i] <= tap1_mag[i];
      end
      ctr_dir <= dir_t'(mid_rd[PW-1 -: 2]);
    end
  end

  // -------------------------------------------------------------------------
  // Compare/select against the two neighbours along the gradient direction
  // -------------------------------------------------------------------------
  logic [NBIT_MAG-1:0] centre;
  logic [NBIT_MAG-1:0] nb_a;
  logic [NBIT_MAG-1:0] nb_b;
  logic [NBIT_MAG-1:0] nms_mag;

  always_comb begin
    centre = tap1_mag[1];
    nb_a   = '0;
    nb_b   = '0;
    case (ctr_dir)
      DIR_H: begin            // W, E
        nb_a = tap2_mag[1];
        nb_b = live_mag[1];
      end
      DIR_45: begin           // NE (r-2,c), SW (r,c-2)
        nb_a = live_mag[0];
        nb_b = tap2_mag[2];
      end
      DIR_V: begin            // N, S
        nb_a = tap1_mag[0];
        nb_b = tap1_mag[2];
      end
      DIR_135: begin          // NW (r-2,c-2), SE (r,c)
        nb_a = tap2_mag[0];
        nb_b = live_mag[2];
      end
      default: begin
        nb_a = '0;
        nb_b = '0;
      end
    endcase
    nms_mag = ((centre >= nb_a) && (centre >= nb_b)) ? centre : '0;
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  logic emit;

  assign emit = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_mag   <= '0;
      o_eof   <= 1'b0;
    end else begin
      o_valid <= emit;
      if (emit) begin
        o_mag <= nms_mag;
        o_eof <= last_pix;
      end
    end
  end

endmodule
